// File: rtl/dmux_pkg.sv
// dmux_pkg: shared helpers for the valid/ready stream demultiplexer.
`define DMUX_SLICE(i, w) (i)*(w) +: (w)
package dmux_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/dmux_chan_reg.sv
// dmux_chan_reg: one-entry output buffer; a load wins over a drain so refill keeps full rate.
module dmux_chan_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] q
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    valid_d = ld | (valid_q & ~ready);
    data_d  = ld ? d : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign q     = data_q;
endmodule

// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-NWAYS demux with per-channel valid/ready and broadcast.
module dmux_stream import dmux_pkg::*; #(
  parameter  int WIDTH = 16,
  parameter  int NWAYS = 4,
  localparam int SEL_W = clog2(NWAYS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  input  logic [WIDTH-1:0]       in_data,
  output logic [NWAYS-1:0]       out_valid,
  input  logic [NWAYS-1:0]       out_ready,
  output logic [NWAYS*WIDTH-1:0] out_data,
  output logic                   err
);
  logic [NWAYS-1:0] can_ld, dec, ld;
  logic             sel_ok, xfer, err_q, err_d;
  // An out-of-range select decodes to all zeros, which is what marks the word as droppable.
  always_comb begin
    can_ld = ~out_valid | out_ready;
    for (int i = 0; i < NWAYS; i++) dec[i] = in_sel == SEL_W'(i);
    sel_ok   = |dec;
    in_ready = in_bcast ? &can_ld : (sel_ok ? |(dec & can_ld) : 1'b1);
    xfer     = in_valid & in_ready;
    ld       = xfer ? (in_bcast ? {NWAYS{1'b1}} : dec) : '0;
    err_d    = xfer & ~in_bcast & ~sel_ok;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
  for (genvar g = 0; g < NWAYS; g++) begin : g_ch
    dmux_chan_reg #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld[g]),
      .d     (in_data),
      .valid (out_valid[g]),
      .ready (out_ready[g]),
      .q     (out_data[`DMUX_SLICE(g, WIDTH)])
    );
  end
endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: directed and random checks of dmux_stream against per-channel scoreboard queues.
module tb_dmux_stream;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_bcast, err;
  logic [1:0]  in_sel;
  logic [15:0] in_data;
  logic [3:0]  out_valid, out_ready;
  logic [63:0] out_data;
  logic        v5, r5, b5, e5;
  logic [2:0]  s5;
  logic [15:0] d5;
  logic [4:0]  ov5, or5;
  logic [79:0] od5;
  logic [15:0] sb[4][$];
  logic        m_rdy;
  int          total, bad;

  dmux_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err)
  );
  dmux_stream #(.WIDTH(16), .NWAYS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5), .in_sel(s5),
    .in_bcast(b5), .in_data(d5), .out_valid(ov5), .out_ready(or5),
    .out_data(od5), .err(e5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ch(input int c);
    return out_data[c*16 +: 16];
  endfunction

  // Drive one cycle, compare against the queues, then apply the handshakes the coming edge performs.
  task automatic cyc(input logic v, input logic [1:0] s, input logic b, input logic [15:0] d,
                     input logic [3:0] ordy);
    logic [3:0] can;
    @(negedge clk);
    in_valid = v; in_sel = s; in_bcast = b; in_data = d; out_ready = ordy;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("out_valid", out_valid[c], sb[c].size() != 0);
      if (sb[c].size() != 0) chk("out_data", ch(c), sb[c][0]);
      can[c] = sb[c].size() == 0 || ordy[c];
    end
    m_rdy = b ? &can : can[s];
    chk("in_ready", in_ready, m_rdy);
    chk("err4", err, 1'b0);
    for (int c = 0; c < 4; c++)
      if (sb[c].size() != 0 && ordy[c]) void'(sb[c].pop_front());
    if (v && m_rdy)
      for (int c = 0; c < 4; c++)
        if (b || s == 2'(c)) sb[c].push_back(d);
  endtask

  initial begin
    logic        v, b;
    logic [1:0]  s;
    logic [15:0] d;
    total = 0; bad = 0; m_rdy = 1'b0;
    rst_n = 1'b0;
    in_valid = 0; in_sel = 0; in_bcast = 0; in_data = 0; out_ready = 0;
    v5 = 0; s5 = 0; b5 = 0; d5 = 0; or5 = '1;
    #1;
    chk("rst_valid", out_valid, 4'b0);
    chk("rst_data", out_data, 64'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // routing, back-to-back
    cyc(1, 0, 0, 16'h1111, 4'hF);
    cyc(1, 1, 0, 16'h2222, 4'hF);
    chk("t1_v0", out_valid, 4'b0001); chk("t1_d0", ch(0), 16'h1111);
    cyc(1, 2, 0, 16'h3333, 4'hF);
    chk("t1_v1", out_valid, 4'b0010); chk("t1_d1", ch(1), 16'h2222);
    cyc(1, 3, 0, 16'h4444, 4'hF);
    chk("t1_v2", out_valid, 4'b0100); chk("t1_d2", ch(2), 16'h3333);
    cyc(0, 0, 0, 16'h0, 4'hF);
    chk("t1_v3", out_valid, 4'b1000); chk("t1_d3", ch(3), 16'h4444);
    cyc(0, 0, 0, 16'h0, 4'hF);

    // backpressure on channel 2
    cyc(1, 2, 0, 16'hAAAA, 4'b1011);
    cyc(1, 2, 0, 16'hBBBB, 4'b1011);
    chk("t2_stall", in_ready, 1'b0); chk("t2_hold", ch(2), 16'hAAAA);
    cyc(1, 2, 0, 16'hBBBB, 4'b1011);
    chk("t2_stall2", in_ready, 1'b0); chk("t2_hold2", ch(2), 16'hAAAA);
    cyc(1, 2, 0, 16'hBBBB, 4'b1111);
    chk("t2_go", in_ready, 1'b1);
    cyc(0, 0, 0, 16'h0, 4'b1111);
    chk("t2_v", out_valid, 4'b0100); chk("t2_d", ch(2), 16'hBBBB);
    cyc(0, 0, 0, 16'h0, 4'b1111);

    // broadcast waits for every channel
    cyc(1, 3, 0, 16'h3333, 4'b0111);
    cyc(1, 0, 1, 16'h5A5A, 4'b0111);
    chk("t3_stall", in_ready, 1'b0); chk("t3_v", out_valid, 4'b1000);
    cyc(1, 0, 1, 16'h5A5A, 4'b1111);
    chk("t3_go", in_ready, 1'b1);
    cyc(0, 0, 0, 16'h0, 4'b1111);
    chk("t3_all", out_valid, 4'b1111);
    for (int c = 0; c < 4; c++) chk("t3_d", ch(c), 16'h5A5A);
    cyc(0, 0, 0, 16'h0, 4'b1111);

    // out-of-range select on the 5-way instance
    @(negedge clk); v5 = 1; s5 = 3'd6; d5 = 16'h0F0F; #1;
    chk("t4_rdy", r5, 1'b1); chk("t4_err0", e5, 1'b0);
    @(negedge clk); v5 = 0; #1;
    chk("t4_err", e5, 1'b1); chk("t4_v", ov5, 5'b0);
    @(negedge clk); v5 = 1; s5 = 3'd4; d5 = 16'h1234; #1;
    chk("t4_err_end", e5, 1'b0); chk("t4_rdy4", r5, 1'b1);
    @(negedge clk); v5 = 0; #1;
    chk("t4_v4", ov5, 5'b10000); chk("t4_d4", od5[64 +: 16], 16'h1234); chk("t4_noerr", e5, 1'b0);

    // asynchronous reset with all channels full
    for (int c = 0; c < 4; c++) cyc(1, 2'(c), 0, 16'hC000 + 16'(c), 4'b0000);
    cyc(0, 0, 0, 16'h0, 4'b0000);
    chk("t5_full", out_valid, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_v", out_valid, 4'b0); chk("t5_d", out_data, 64'b0); chk("t5_v5", ov5, 5'b0);
    for (int c = 0; c < 4; c++) sb[c].delete();
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 1, 0, 16'hBEEF, 4'hF);
    cyc(0, 0, 0, 16'h0, 4'hF);
    chk("t5_post_v", out_valid, 4'b0010); chk("t5_post_d", ch(1), 16'hBEEF);

    // random traffic honouring the producer hold rule
    v = 0; s = 0; b = 0; d = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!(v && !m_rdy)) begin
        v = $urandom_range(0, 3) != 0;
        s = 2'($urandom_range(0, 3));
        b = $urandom_range(0, 7) == 0;
        d = 16'($urandom);
      end
      cyc(v, s, b, d, 4'($urandom));
    end
    repeat (4) cyc(0, 0, 0, 16'h0, 4'hF);
    chk("drain", out_valid, 4'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
